// File: rtl/integrador_v2.sv
// integrador_v2: fixed-point integrator v <= sat16(v + ((a*dt) >>> FRAC)) using a 16-cycle shift-add multiplier
module integrador_v2 #(
  parameter int FRAC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] dt,
  input  logic        enable,
  output logic [15:0] v,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MULT, ACC} state_t;
  state_t state_q, state_d;
  logic signed [15:0] a_q, a_d;
  logic [15:0] dt_q, dt_d;
  logic signed [32:0] prod_q, prod_d;
  logic [3:0] cnt_q, cnt_d;
  logic [15:0] v_q, v_d;
  logic busy_q, busy_d;
  logic start;
  logic signed [32:0] a_ext, addend, inc;
  logic signed [33:0] sum;
  logic [15:0] sat_v;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      dt_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      v_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      dt_q    <= dt_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (enable ? MULT : IDLE) :
              (state_q == MULT) ? ((cnt_q == 4'd15) ? ACC : MULT) : IDLE;
  end
  // Sum is formed at 34 bits so the saturation test sees the true signed result.
  always_comb begin
    start  = (state_q == IDLE) && enable;
    a_ext  = {{17{a_q[15]}}, a_q};
    addend = a_ext <<< cnt_q;
    inc    = prod_q >>> FRAC;
    sum    = {{18{v_q[15]}}, v_q} + {inc[32], inc};
    sat_v  = (sum > 34'sd32767) ? 16'h7FFF : (sum < -34'sd32768) ? 16'h8000 : sum[15:0];
    a_d    = start ? a : a_q;
    dt_d   = start ? dt : dt_q;
    prod_d = start ? '0 : ((state_q == MULT) && dt_q[cnt_q]) ? prod_q + addend : prod_q;
    cnt_d  = start ? '0 : (state_q == MULT) ? cnt_q + 4'd1 : cnt_q;
    v_d    = (state_q == ACC) ? sat_v : v_q;
    busy_d = start ? 1'b1 : (state_q == ACC) ? 1'b0 : busy_q;
  end
  assign v    = v_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_integrador_v2.sv
// tb_integrador_v2: table-driven integration steps plus reset, continuous-enable and mid-step abort sequences
module tb_integrador_v2;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] dt = '0;
  logic        enable = 1'b0;
  logic [15:0] v;
  logic        busy;
  int ncmp = 0;
  int nerr = 0;

  integrador_v2 #(.FRAC(8)) dut (.clk(clk), .rst(rst), .a(a), .dt(dt), .enable(enable), .v(v), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    bit          do_rst;
    bit          scr;
    logic [15:0] a;
    logic [15:0] dt;
    logic [15:0] exp_v;
  } vec_t;
  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst v", 32'(v), 32'd0);
    rst = 1'b1;
  endtask

  task automatic do_step(input string nm, input logic [15:0] sa, input logic [15:0] sd,
                         input bit scr, input logic [15:0] ev);
    int n;
    bit moved;
    logic [15:0] v0;
    @(negedge clk);
    v0 = v;
    a = sa;
    dt = sd;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    if (scr) begin
      a = 16'h7FFF;
      dt = 16'hFFFF;
    end
    n = 0;
    moved = 1'b0;
    while (busy && n < 40) begin
      if (v !== v0) moved = 1'b1;
      n++;
      @(negedge clk);
    end
    chk({nm, " busy_cycles"}, 32'(n), 32'd17);
    chk({nm, " v_hold"}, 32'(moved), 32'd0);
    chk({nm, " v"}, 32'(v), 32'(ev));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    bit seen;
    vecs[0]  = '{1'b1, 1'b0, 16'h00AA, 16'd10,   16'h0006};
    vecs[1]  = '{1'b0, 1'b0, 16'h00AA, 16'd10,   16'h000C};
    vecs[2]  = '{1'b1, 1'b1, 16'h00AA, 16'd10,   16'h0006};
    vecs[3]  = '{1'b1, 1'b0, 16'hFF00, 16'd1,    16'hFFFF};
    vecs[4]  = '{1'b0, 1'b0, 16'hFFFF, 16'd1,    16'hFFFE};
    vecs[5]  = '{1'b1, 1'b0, 16'h7FFF, 16'hFFFF, 16'h7FFF};
    vecs[6]  = '{1'b0, 1'b0, 16'h7FFF, 16'hFFFF, 16'h7FFF};
    vecs[7]  = '{1'b0, 1'b0, 16'h8000, 16'hFFFF, 16'h8000};
    vecs[8]  = '{1'b0, 1'b0, 16'h8000, 16'hFFFF, 16'h8000};
    vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'h1234, 16'h8000};
    vecs[10] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'h8000};
    vecs[11] = '{1'b1, 1'b0, 16'h0001, 16'h0100, 16'h0001};
    vecs[12] = '{1'b0, 1'b0, 16'hFFFF, 16'h00FF, 16'h0000};
    vecs[13] = '{1'b1, 1'b0, 16'h0002, 16'h8000, 16'h0100};
    vecs[14] = '{1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100};

    rst = 1'b0;
    enable = 1'b1;
    a = 16'h00AA;
    dt = 16'd10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold_rst busy %0d", i), 32'(busy), 32'd0);
      chk($sformatf("hold_rst v %0d", i), 32'(v), 32'd0);
    end
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_rst) rst_pulse();
      do_step($sformatf("vec%0d", i), vecs[i].a, vecs[i].dt, vecs[i].scr, vecs[i].exp_v);
    end

    rst_pulse();
    @(negedge clk);
    a = 16'h0100;
    dt = 16'h0100;
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (busy && n < 40) begin
        n++;
        @(negedge clk);
      end
      chk($sformatf("cont%0d busy_cycles", i), 32'(n), 32'd17);
      chk($sformatf("cont%0d v", i), 32'(v), 32'(256 * (i + 1)));
      @(negedge clk);
      chk($sformatf("cont%0d restart", i), 32'(busy), 32'd1);
    end
    enable = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("cont drain v", 32'(v), 32'h400);

    rst_pulse();
    @(negedge clk);
    a = 16'h7FFF;
    dt = 16'hFFFF;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort busy_now", 32'(busy), 32'd0);
    chk("abort v", 32'(v), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (busy || v != 16'h0) seen = 1'b1;
    end
    chk("abort no_resume", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
